instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 93 +++++++++
 rtl/instr_fifo.sv | 44 ++++
 rtl/instr_encoder.sv | 90 +++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: request kinds, MIPS opcode/funct
// constants, error codes and the combinational encode function.
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        K_ADDU  = 4'd0,
        K_SUBU  = 4'd1,
        K_AND   = 4'd2,
        K_OR    = 4'd3,
        K_SLTU  = 4'd4,
        K_LW    = 4'd5,
        K_SW    = 4'd6,
        K_BEQ   = 4'd7,
        K_ADDIU = 4'd8,
        K_J     = 4'd9,
        K_NOP   = 4'd10
    } kind_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_KIND   = 2'd1,
        ERR_RANGE  = 2'd2,
        ERR_TARGET = 2'd3
    } err_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [31:0] NOP_WORD = 32'h0000_0021;

    typedef struct packed {
        logic [31:0] word;
        err_e        code;
    } enc_t;

    function automatic enc_t encode(input logic [3:0] kind, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [31:0] imm, input logic [31:0] pc);
        enc_t               r;
        logic [31:0]        pc4;
        logic signed [31:0] off;
        logic               imm_ok;
        logic               off_ok;
        pc4    = pc + 32'd4;
        off    = $signed(imm - pc4) >>> 2;
        imm_ok = (imm[31:15] == '0) || (imm[31:15] == '1);
        off_ok = (off[31:15] == '0) || (off[31:15] == '1);
        r.word = '0;
        r.code = ERR_NONE;
        case (kind_e'(kind))
            K_ADDU:  r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADDU};
            K_SUBU:  r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUBU};
            K_AND:   r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            K_OR:    r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            K_SLTU:  r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLTU};
            K_NOP:   r.word = NOP_WORD;
            K_ADDIU: begin
                r.word = {OP_ADDIU, rs, rt, imm[15:0]};
                if (!imm_ok) r.code = ERR_RANGE;
            end
            K_LW: begin
                r.word = {OP_LW, rs, rt, imm[15:0]};
                if (!imm_ok) r.code = ERR_RANGE;
            end
            K_SW: begin
                r.word = {OP_SW, rs, rt, imm[15:0]};
                if (!imm_ok) r.code = ERR_RANGE;
            end
            K_BEQ: begin
                r.word = {OP_BEQ, rs, rt, off[15:0]};
                if (imm[1:0] != 2'b00) r.code = ERR_TARGET;
                else if (!off_ok)      r.code = ERR_RANGE;
            end
            K_J: begin
                r.word = {OP_J, imm[27:2]};
                if (imm[1:0] != 2'b00 || imm[31:28] != pc4[31:28]) r.code = ERR_TARGET;
            end
            default: r.code = ERR_KIND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with registered storage; a push into an empty FIFO becomes
// visible one cycle later, so there is no fall-through path.
module instr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !clear) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into MIPS words at an advancing pc and buffers
// {address, word} pairs for writing into instruction memory.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    output logic        imem_we,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] words_written
);
    typedef enum logic {S_RUN, S_ERROR} state_e;

    state_e      state;
    logic [31:0] pc;
    err_e        err_code_q;
    enc_t        enc;
    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb enc = encode(in_kind, in_rs, in_rt, in_rd, in_imm, pc);

    // reset_n gating keeps in_ready low for the whole reset window
    assign in_ready = reset_n && !full && (state == S_RUN);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (enc.code == ERR_NONE) && !flush;
    assign pop      = imem_we && imem_ready && !flush;
    assign imem_we  = !empty;
    assign err_code = err_code_q;

    instr_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .push    (push),
        .wdata   ({pc, enc.word}),
        .pop     (pop),
        .rdata   ({imem_addr, imem_wdata}),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_RUN;
            pc            <= BASE_ADDR;
            err           <= 1'b0;
            err_code_q    <= ERR_NONE;
            words_written <= '0;
        end else if (flush) begin
            state      <= S_RUN;
            pc         <= BASE_ADDR;
            err        <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (pop) words_written <= words_written + 16'd1;
            if (accept) begin
                if (enc.code == ERR_NONE) begin
                    pc <= pc + 32'd4;
                end else begin
                    state      <= S_ERROR;
                    err        <= 1'b1;
                    err_code_q <= enc.code;
                end
            end
        end
    end

endmodule
